ser_tx_arbiter: RTL
===================

SER_TX_ARBITER -- requirements
Module: ser_tx_arbiter

Interface
REQ-001 Parameter DEFAULT_DIV, default 106, meaning the clocks-per-bit value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 cfg_div_we  input  1  writes cfg_div_di into the divider register when high.
REQ-005 cfg_div_di  input  32  new clocks-per-bit value.
REQ-006 cfg_div_do  output  32  current divider register contents, exactly as written.
REQ-007 req0_valid  input  1  requester 0 has a byte pending.
REQ-008 req0_data  input  8  requester 0 byte.
REQ-009 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-010 req1_valid, req1_data, req1_ready  same directions and widths as requester 0, for requester 1.
REQ-011 ser_tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 grant_id  output  1  requester index of the frame in progress, or of the last frame when idle.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE SHALL grant a requester when any valid is high.
- Only one valid high: that requester wins.
- Both high: the requester not named by grant_id wins (round-robin).
REQ-016 readyN SHALL be combinational and high only in IDLE for the granted requester.
- A valid&&ready cycle transfers the byte.
- No ready SHALL assert outside IDLE.
REQ-017 On acceptance the block SHALL latch data, the winner index, and effective divisor = max(cfg_div_do, 2).
- It then enters START.
- ser_tx SHALL go low on the next cycle.
REQ-018 Bit timing SHALL use the latched divisor: START, each of the 8 DATA bits, and STOP each hold for exactly divisor cycles.
- Frame length SHALL be 10 x divisor cycles.
REQ-019 DATA SHALL shift out bit0 first, using a 3-bit bit counter that terminates after bit7.
REQ-020 STOP SHALL drive ser_tx high, then return to IDLE.
- Minimum gap between frame end and the next START SHALL be exactly 1 cycle (the IDLE acceptance cycle).
REQ-021 cfg_div_we SHALL update the register on the next edge in any state.
- A frame in progress SHALL keep its latched divisor.
- The new value SHALL apply from the next acceptance.
REQ-022 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-023 Dropping valid without a handshake SHALL have no effect.
- Requesters SHALL hold data stable while valid is high.
- The block does not check this.
REQ-024 ser_tx SHALL be registered (glitch-free) in every state.

Reset
REQ-025 While resetn is low, outputs SHALL be:
- ser_tx=1, busy=0, req0_ready=req1_ready=0;
- grant_id=1, so requester 0 wins the first contention;
- cfg_div_do=DEFAULT_DIV; state=IDLE; all counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately.
- ser_tx=1 asynchronously.
- The partial byte is discarded.
- Neither requester is re-acknowledged.
REQ-027 After resetn deasserts, the first acceptance SHALL be possible on the first clock edge.

Verification
REQ-028 After reset, pulse req0_valid with req0_data=0x41 (div 106) -> one-cycle req0_ready; ser_tx low 106 cycles, then bits 1,0,0,0,0,0,1,0; stop high; busy high 1060 cycles; bench decodes 'A'.
REQ-029 req0 (0x55) and req1 (0xAA) both valid continuously from reset -> frames alternate 0x55, 0xAA, 0x55 ...; grant_id alternates 0,1,0; 1-cycle IDLE gap between frames.
REQ-030 Write cfg_div_di=20 during the 3rd DATA bit of a frame -> current frame stays 1060 cycles; next frame is 200 cycles; cfg_div_do=20 the cycle after the write.
REQ-031 Write cfg_div_di=0, send 0xFF -> bit period 2 cycles, frame 20 cycles; cfg_div_do reads 0.
REQ-032 Assert resetn low at cycle 500 of a frame -> ser_tx=1 and busy=0 with no clock edge; cfg_div_do=106; next req1 byte 0x0D transmits cleanly; requester 0 wins the first contention after reset.
REQ-033 Only req1 valid, repeatedly (0x31, 0x32) -> req1 granted every frame regardless of grant_id; req0_ready never asserts.

Source files
------------

// File: rtl/ser_tx_arbiter.sv
// ser_tx_arbiter: two-requester round-robin arbiter feeding an 8N1
// serial transmitter (LSB first, idle high) with a programmable divisor.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   cfg_div_we/di/do    clocks-per-bit register write enable, data in, readback
//   reqN_valid/data     requester N byte offer (N = 0, 1)
//   reqN_ready          combinational accept for requester N (IDLE only)
//   ser_tx              registered serial line
//   busy                high while a frame is in progress
//   grant_id            requester of the current (or last) frame
module ser_tx_arbiter #(
    parameter int unsigned DEFAULT_DIV = 106
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_div_we,
    input  logic [31:0] cfg_div_di,
    output logic [31:0] cfg_div_do,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        ser_tx,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q;
    logic [31:0] cfg_q;
    logic [31:0] div_q;
    logic [31:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        ser_tx_q;
    logic        busy_q;
    logic        grant_q;

    logic        win1;
    logic        idle_ok;
    logic        accept;
    logic        last_cnt;
    logic [31:0] eff_div;

    // Requester 1 wins when it is alone, or on contention when the
    // previous frame belonged to requester 0.
    assign win1     = req1_valid && (!req0_valid || !grant_q);
    // Gating with resetn keeps both readies low while reset is held.
    assign idle_ok  = resetn && (state_q == IDLE);
    assign req0_ready = idle_ok && req0_valid && !win1;
    assign req1_ready = idle_ok && win1;
    assign accept   = req0_ready || req1_ready;
    // Divisors below 2 are clamped so every bit lasts at least 2 cycles.
    assign eff_div  = (cfg_q < 32'd2) ? 32'd2 : cfg_q;
    assign last_cnt = (cnt_q == div_q - 32'd1);

    assign cfg_div_do = cfg_q;
    assign ser_tx     = ser_tx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cfg_q    <= DEFAULT_DIV;
            div_q    <= 32'd0;
            cnt_q    <= 32'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            ser_tx_q <= 1'b1;
            busy_q   <= 1'b0;
            grant_q  <= 1'b1;
        end else begin
            if (cfg_div_we) begin
                cfg_q <= cfg_div_di;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= START;
                        shift_q  <= win1 ? req1_data : req0_data;
                        grant_q  <= win1;
                        div_q    <= eff_div;
                        cnt_q    <= 32'd0;
                        bit_q    <= 3'd0;
                        ser_tx_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (last_cnt) begin
                        cnt_q    <= 32'd0;
                        state_q  <= DATA;
                        ser_tx_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DATA: begin
                    if (last_cnt) begin
                        cnt_q <= 32'd0;
                        if (bit_q == 3'd7) begin
                            state_q  <= STOP;
                            ser_tx_q <= 1'b1;
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            ser_tx_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                STOP: begin
                    if (last_cnt) begin
                        cnt_q   <= 32'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
